// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe referee: human plays O through a move handshake, an external combinational AI plays X.
// Define TTT_AI_FIRST_EN to make start hand the first move to X.
module ttt_game_ctrl #(
  parameter int AI_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_idx,
  output logic       move_ready,
  output logic       move_err,
  input  logic [8:0] ai_move,
  output logic [8:0] x_state,
  output logic [8:0] o_state,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       ai_fault,
  output logic [3:0] x_wins,
  output logic [3:0] o_wins,
  output logic [3:0] draws
);

  typedef enum logic [2:0] {IDLE, HUMAN, CHK_O, AI_WAIT, AI_APPLY, CHK_X, OVER} state_t;

`ifdef TTT_AI_FIRST_EN
  localparam state_t START_STATE = AI_WAIT;
`else
  localparam state_t START_STATE = HUMAN;
`endif

  localparam logic [3:0] WAIT_LOAD = 4'(AI_DELAY - 1);

  state_t     state, state_n;
  logic [3:0] wait_cnt;
  logic [8:0] occupied, human_mask;
  logic       hs, human_ok, ai_ok, o_line, x_line, full;

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    occupied   = x_state | o_state;
    human_mask = (move_idx <= 4'd8) ? (9'd1 << move_idx) : 9'd0;
    hs         = move_valid && (state == HUMAN);
    human_ok   = (human_mask != 9'd0) && ((human_mask & occupied) == 9'd0);
    // AI move must be exactly one-hot and land on an empty cell
    ai_ok      = (ai_move != 9'd0) && ((ai_move & (ai_move - 9'd1)) == 9'd0) &&
                 ((ai_move & occupied) == 9'd0);
    o_line     = has_line(o_state);
    x_line     = has_line(x_state);
    full       = &occupied;
  end

  assign move_ready = (state == HUMAN);
  assign turn       = (state == AI_WAIT) || (state == AI_APPLY);
  assign game_over  = (state == OVER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, OVER: if (start) state_n = START_STATE;
      HUMAN:      if (hs && human_ok) state_n = CHK_O;
      CHK_O:      state_n = (o_line || full) ? OVER : AI_WAIT;
      AI_WAIT:    if (wait_cnt == 4'd0) state_n = AI_APPLY;
      AI_APPLY:   state_n = ai_ok ? CHK_X : OVER;
      CHK_X:      state_n = (x_line || full) ? OVER : HUMAN;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_state  <= '0;
      o_state  <= '0;
      winner   <= 2'b00;
      ai_fault <= 1'b0;
      move_err <= 1'b0;
      x_wins   <= '0;
      o_wins   <= '0;
      draws    <= '0;
      wait_cnt <= '0;
    end else begin
      move_err <= 1'b0;
      // counter is loaded on entry so AI_WAIT dwells exactly AI_DELAY cycles
      if (state_n == AI_WAIT && state != AI_WAIT) wait_cnt <= WAIT_LOAD;
      else if (state == AI_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            x_state  <= '0;
            o_state  <= '0;
            winner   <= 2'b00;
            ai_fault <= 1'b0;
          end
        end
        HUMAN: begin
          if (hs) begin
            if (human_ok) o_state <= o_state | human_mask;
            else          move_err <= 1'b1;
          end
        end
        CHK_O: begin
          if (o_line) begin
            winner <= 2'b10;
            o_wins <= sat_inc(o_wins);
          end else if (full) begin
            winner <= 2'b11;
            draws  <= sat_inc(draws);
          end
        end
        AI_APPLY: begin
          if (ai_ok) begin
            x_state <= x_state | ai_move;
          end else begin
            ai_fault <= 1'b1;
            winner   <= 2'b00;
          end
        end
        CHK_X: begin
          if (x_line) begin
            winner <= 2'b01;
            x_wins <= sat_inc(x_wins);
          end else if (full) begin
            winner <= 2'b11;
            draws  <= sat_inc(draws);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed games plus random games scored against a cell-array model of the rules.
module tb_ttt_game_ctrl;
  localparam int AI_DELAY = 4;
  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic       clk = 1'b0;
  logic       rst, start, move_valid;
  logic [3:0] move_idx;
  logic       move_ready, move_err;
  logic [8:0] ai_move, x_state, o_state;
  logic       turn, game_over;
  logic [1:0] winner;
  logic       ai_fault;
  logic [3:0] x_wins, o_wins, draws;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 empty, 1 X, 2 O; winner 0 none/fault, 1 X, 2 O, 3 draw
  int board [9];
  int m_win, m_fault, m_xw, m_ow, m_dr;

  ttt_game_ctrl #(.AI_DELAY(AI_DELAY)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_idx(move_idx),
    .move_ready(move_ready), .move_err(move_err), .ai_move(ai_move),
    .x_state(x_state), .o_state(o_state), .turn(turn), .game_over(game_over),
    .winner(winner), .ai_fault(ai_fault), .x_wins(x_wins), .o_wins(o_wins), .draws(draws)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before 900000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mask_of(input int who);
    logic [8:0] m = '0;
    for (int i = 0; i < 9; i++) if (board[i] == who) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit won(input int who);
    for (int l = 0; l < 8; l++)
      if (board[LINES[l][0]] == who && board[LINES[l][1]] == who && board[LINES[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full();
    for (int i = 0; i < 9; i++) if (board[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick_empty();
    int e [$];
    for (int i = 0; i < 9; i++) if (board[i] == 0) e.push_back(i);
    if (e.size() == 0) return -1;
    return e[$urandom_range(0, e.size() - 1)];
  endfunction

  task automatic finish_game(input int w);
    m_win = w;
    if (w == 1 && m_xw < 15) m_xw++;
    if (w == 2 && m_ow < 15) m_ow++;
    if (w == 3 && m_dr < 15) m_dr++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) board[i] = 0;
    m_win = 0; m_fault = 0; m_xw = 0; m_ow = 0; m_dr = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":x_state"}, x_state, mask_of(1));
    check({tag, ":o_state"}, o_state, mask_of(2));
    check({tag, ":winner"}, winner, m_win);
    check({tag, ":ai_fault"}, ai_fault, m_fault);
    check({tag, ":x_wins"}, x_wins, m_xw);
    check({tag, ":o_wins"}, o_wins, m_ow);
    check({tag, ":draws"}, draws, m_dr);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) board[i] = 0;
    m_win = 0;
    m_fault = 0;
    check("start_ready", move_ready, 1);
    check("start_not_over", game_over, 0);
    check_all("start");
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 64 && move_ready !== 1'b1; i++) tick();
    ok = (move_ready === 1'b1);
    check("ready_wait", move_ready, 1);
  endtask

  task automatic human_try(input int idx, output bit accepted);
    bit ok, legal;
    accepted = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    legal = 1'b0;
    if (idx <= 8) legal = (board[idx] == 0);
    move_valid = 1'b1;
    move_idx = 4'(idx);
    tick();
    move_valid = 1'b0;
    if (legal) begin
      board[idx] = 2;
      accepted = 1'b1;
      check("o_set", o_state, mask_of(2));
      check("ready_drop", move_ready, 0);
      check("no_err_on_accept", move_err, 0);
    end else begin
      check("err_pulse", move_err, 1);
      check("err_stays_human", move_ready, 1);
      check_all("err_board");
      tick();
      check("err_one_cycle", move_err, 0);
    end
  endtask

  // called one ns after the accepted human edge E
  task automatic ai_phase(input logic [8:0] mask, output bit over);
    int cnt, pos;
    bit legal;
    over = 1'b0;
    tick();
    if (won(2)) begin
      finish_game(2);
      check("o_win_over", game_over, 1);
      check_all("o_win");
      over = 1'b1;
      return;
    end
    if (full()) begin
      finish_game(3);
      check("draw_o_over", game_over, 1);
      check_all("draw_o");
      over = 1'b1;
      return;
    end
    ai_move = mask;
    for (int k = 0; k < AI_DELAY; k++) begin
      check("wait_turn", turn, 1);
      check("x_hold", x_state, mask_of(1));
      check("busy_no_err", move_err, 0);
      move_valid = 1'($urandom_range(0, 1));
      move_idx = 4'($urandom_range(0, 15));
      tick();
    end
    move_valid = 1'b0;
    check("apply_turn", turn, 1);
    check("x_hold_apply", x_state, mask_of(1));
    check("busy_no_err_apply", move_err, 0);
    check("o_unchanged_busy", o_state, mask_of(2));
    tick();
    cnt = 0;
    pos = 0;
    for (int i = 0; i < 9; i++) if (mask[i]) begin cnt++; pos = i; end
    legal = (cnt == 1) && (board[pos] == 0);
    if (!legal) begin
      m_fault = 1;
      m_win = 0;
      check("fault_over", game_over, 1);
      check("fault_turn", turn, 0);
      check_all("fault");
      over = 1'b1;
      return;
    end
    board[pos] = 1;
    check("x_set", x_state, mask_of(1));
    check("chk_x_not_ready", move_ready, 0);
    tick();
    if (won(1) || full()) begin
      finish_game(won(1) ? 1 : 3);
      check("x_phase_over", game_over, 1);
      over = 1'b1;
    end else begin
      check("ready_back", move_ready, 1);
      check("not_over", game_over, 0);
    end
    check_all("after_x");
  endtask

  initial begin
    bit acc, over;
    int idx, e;
    logic [8:0] mask;
    int o_seq [5] = '{0, 2, 3, 7, 8};
    int x_seq [4] = '{1, 4, 5, 6};

    rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_idx = '0; ai_move = '0;
    model_reset();
    #12;
    check_all("reset");
    check("reset_ready", move_ready, 0);
    check("reset_turn", turn, 0);
    check("reset_over", game_over, 0);
    check("reset_err", move_err, 0);
    #1 rst = 1'b0;
    tick(); tick(); tick();
    check("idle_hold_ready", move_ready, 0);
    check("idle_hold_over", game_over, 0);

    // first move and AI latency
    start_game();
    human_try(4, acc);
    ai_phase(9'h001, over);
    check("first_o", o_state, 9'h010);
    check("first_x", x_state, 9'h001);

    // rejected human moves, then an AI fault ends the game
    human_try(4, acc);
    human_try(12, acc);
    human_try(8, acc);
    ai_phase(9'h003, over);
    check("fault_flag", ai_fault, 1);

    // AI picks an occupied cell
    start_game();
    human_try(0, acc);
    ai_phase(9'h001, over);
    check("fault_occupied", ai_fault, 1);

    // O wins along the top row
    start_game();
    human_try(0, acc); ai_phase(9'h008, over);
    human_try(1, acc); ai_phase(9'h010, over);
    human_try(2, acc); ai_phase(9'h000, over);
    check("o_row_winner", winner, 2'b10);
    check("o_row_over", game_over, 1);
    check("o_row_count", o_wins, 1);
    start_game();
    check("cleared_x", x_state, 9'h000);
    check("cleared_o", o_state, 9'h000);

    // sixteen drawn games saturate the draw counter
    for (int d = 0; d < 16; d++) begin
      if (d > 0) start_game();
      for (int t = 0; t < 5; t++) begin
        human_try(o_seq[t], acc);
        ai_phase((t < 4) ? (9'd1 << x_seq[t]) : 9'd0, over);
      end
      check("draw_winner", winner, 2'b11);
    end
    check("draws_saturated", draws, 15);

    // random games
    for (int g = 0; g < 30; g++) begin
      start_game();
      over = 1'b0;
      for (int a = 0; a < 60 && !over; a++) begin
        if ($urandom_range(0, 6) == 0) idx = int'($urandom_range(0, 15));
        else idx = pick_empty();
        human_try(idx, acc);
        if (acc) begin
          e = pick_empty();
          mask = (e < 0) ? 9'd0 : (9'd1 << e);
          if ($urandom_range(0, 15) == 0) mask = 9'($urandom_range(0, 511));
          ai_phase(mask, over);
        end
      end
      check("random_game_ended", game_over, 1);
    end

    // start ignored and reset honoured during AI_WAIT
    start_game();
    human_try(4, acc);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_turn", turn, 1);
    check("start_ignored_board", o_state, 9'h010);
    check("start_ignored_ready", move_ready, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset_turn", turn, 0);
    check("async_reset_over", game_over, 0);
    check("async_reset_ready", move_ready, 0);
    #3 rst = 1'b0;
    tick(); tick();
    check("post_reset_idle", move_ready, 0);
    check("post_reset_turn", turn, 0);
    check_all("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
